// File: rtl/spi_shift_engine.sv
// SPI shift engine: serialises one word onto mosi and collects one word from miso,
//   paced by strobes from an external clk/cs generator.
// Latency: start pulses 1 cycle after acceptance; rx_valid pulses 1 cycle after the DONE state.
// Backpressure: start_req is ignored while busy=1, and a request made then is not queued.
//
// Optional feature:
//   `define SPI_SHIFT_LOOPBACK_EN adds the loopback input. With loopback=1, rx sampling
//   uses the registered mosi instead of miso. Without the macro, rx always samples miso.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start_req       request one transfer (accepted in IDLE only)
//   tx_data         word to send, right-justified (sampled on acceptance)
//   data_len        transfer length in bits (sampled on acceptance)
//   msb_first       bit order (sampled on acceptance)
//   spi_cs          active-low chip select from the generator
//   tx_shift_en     generator strobe: present the next bit on mosi
//   rx_shift_en     generator strobe: sample the serial input
//   miso            serial input, already synchronised
//   loopback        (only with SPI_SHIFT_LOOPBACK_EN) sample mosi instead of miso
//   start           one-cycle kick to the generator
//   mosi            registered serial output
//   busy            high from acceptance until the return to IDLE
//   rx_data         received word, right-justified, held until the next completion
//   rx_valid        one-cycle pulse; rx_data is valid in the same cycle
module spi_shift_engine #(
  parameter int DATA_W = 16  // maximum word width, 8..32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_req,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [7:0]        data_len,
  input  logic              msb_first,
  input  logic              spi_cs,
  input  logic              tx_shift_en,
  input  logic              rx_shift_en,
  input  logic              miso,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              start,
  output logic              mosi,
  output logic              busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_CS = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [7:0] DATA_W_8 = 8'(DATA_W);

  logic [1:0]        state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [7:0]        len_q;
  logic [7:0]        bit_cnt;
  logic              msb_q;
  logic [7:0]        len_clamped;
  logic              rx_bit;

  // Transfers longer than the register still run for data_len strobes.
  // Only the first DATA_W bits carry data, so the alignment shifts use the clamped length.
  assign len_clamped = (data_len > DATA_W_8) ? DATA_W_8 : data_len;

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign rx_bit = loopback ? mosi : miso;
`else
  assign rx_bit = miso;
`endif

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      start    <= 1'b0;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      len_q    <= '0;
      bit_cnt  <= '0;
      msb_q    <= 1'b0;
    end else begin
      start    <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          mosi <= 1'b0;
          if (start_req) begin
            msb_q   <= msb_first;
            len_q   <= len_clamped;
            // MSB-first: left-align the word so that the outgoing bit always sits at
            // DATA_W-1. A shift of DATA_W (length 0) empties the register.
            tx_sr   <= msb_first ? (tx_data << (DATA_W_8 - len_clamped)) : tx_data;
            rx_sr   <= '0;
            bit_cnt <= '0;
            start   <= 1'b1;
            state   <= ST_WAIT_CS;
          end
        end

        ST_WAIT_CS: begin
          mosi <= 1'b0;
          if (!spi_cs) begin
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // Zeros are shifted in, so strobes past DATA_W drive mosi low.
          if (tx_shift_en) begin
            if (msb_q) begin
              mosi  <= tx_sr[DATA_W-1];
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end else begin
              mosi  <= tx_sr[0];
              tx_sr <= {1'b0, tx_sr[DATA_W-1:1]};
            end
          end
          if (rx_shift_en) begin
            if (msb_q) begin
              rx_sr <= {rx_sr[DATA_W-2:0], rx_bit};
            end else begin
              rx_sr <= {rx_bit, rx_sr[DATA_W-1:1]};
            end
            if (bit_cnt != 8'hFF) begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
          if (spi_cs) begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          mosi     <= 1'b0;
          // LSB-first data enters at the top of the register and is right-justified here.
          // With length 0 the shift is DATA_W, so the result is zero.
          rx_data  <= msb_q ? rx_sr : (rx_sr >> (DATA_W_8 - len_q));
          rx_valid <= 1'b1;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine. It plays the clk/cs generator,
//   checks every mosi bit and each received word against a bit-list reference model,
//   and checks reset, busy, and the single-pulse behaviour.
module tb_spi_shift_engine;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_req;
  logic [DW-1:0] tx_data;
  logic [7:0]    data_len;
  logic          msb_first;
  logic          spi_cs;
  logic          tx_shift_en;
  logic          rx_shift_en;
  logic          miso;
`ifdef SPI_SHIFT_LOOPBACK_EN
  logic          loopback;
`endif
  logic          start;
  logic          mosi;
  logic          busy;
  logic [DW-1:0] rx_data;
  logic          rx_valid;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int rxv_cnt = 0;
  bit rxq[$];

  always #5 clk = ~clk;

  spi_shift_engine #(.DATA_W(DW)) dut (
    .clk(clk),
    .reset(reset),
    .start_req(start_req),
    .tx_data(tx_data),
    .data_len(data_len),
    .msb_first(msb_first),
    .spi_cs(spi_cs),
    .tx_shift_en(tx_shift_en),
    .rx_shift_en(rx_shift_en),
    .miso(miso),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loopback(loopback),
`endif
    .start(start),
    .mosi(mosi),
    .busy(busy),
    .rx_data(rx_data),
    .rx_valid(rx_valid)
  );

  always @(negedge clk) begin
    if (start === 1'b1) start_cnt++;
    if (rx_valid === 1'b1) rxv_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected bit on the i-th tx strobe.
  // The first min(len,DW) bits are the word in the chosen order; any further bits are 0.
  function automatic logic exp_mosi(input logic [DW-1:0] tx, input int len, input logic msb, input int i);
    int l;
    l = (len > DW) ? DW : len;
    if (i >= DW) return 1'b0;
    if (msb) return tx[l-1-i];
    return tx[i];
  endfunction

  // Expected word: the last min(n,DW) bits received.
  // For MSB-first the first of them is most significant; for LSB-first it is bit 0.
  function automatic logic [31:0] exp_rx(input logic msb);
    int n;
    int k;
    logic [31:0] v;
    n = rxq.size();
    k = (n > DW) ? DW : n;
    v = 0;
    for (int j = 0; j < k; j++) begin
      if (msb) v = v | (32'(rxq[n-k+j]) << (k-1-j));
      else     v = v | (32'(rxq[n-k+j]) << j);
    end
    return v;
  endfunction

  // mode: 0 random miso, 1 miso echoes mosi, 2 miso constant 1, 3 miso 0 (loopback)
  task automatic xfer(input logic [DW-1:0] tx, input int len, input logic msb, input int mode, input string tag);
    int s0;
    int r0;
    logic e;
    logic b;
    logic seen;
    rxq.delete();
    s0 = start_cnt;
    r0 = rxv_cnt;
    start_req = 1'b1;
    tx_data   = tx;
    data_len  = 8'(len);
    msb_first = msb;
    step();
    start_req = 1'b0;
    check({tag, "/start"}, 32'(start), 32'd1);
    check({tag, "/busy"}, 32'(busy), 32'd1);
    step();
    check({tag, "/mosi_wait"}, 32'(mosi), 32'd0);
    spi_cs = 1'b0;
    step();
    for (int i = 0; i < len; i++) begin
      tx_shift_en = 1'b1;
      step();
      tx_shift_en = 1'b0;
      e = exp_mosi(tx, len, msb, i);
      check($sformatf("%s/mosi%0d", tag, i), 32'(mosi), 32'(e));
      case (mode)
        0:       begin b = 1'($urandom); miso = b; end
        1:       begin b = e; miso = mosi; end
        2:       begin b = 1'b1; miso = 1'b1; end
        default: begin b = e; miso = 1'b0; end
      endcase
      rx_shift_en = 1'b1;
      step();
      rx_shift_en = 1'b0;
      rxq.push_back(b);
    end
    spi_cs = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (rx_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "/rx_valid"}, 32'(seen), 32'd1);
    check({tag, "/rx_data"}, 32'(rx_data), exp_rx(msb));
    step();
    check({tag, "/busy_end"}, 32'(busy), 32'd0);
    check({tag, "/mosi_idle"}, 32'(mosi), 32'd0);
    check({tag, "/start_cnt"}, 32'(start_cnt - s0), 32'd1);
    check({tag, "/rxv_cnt"}, 32'(rxv_cnt - r0), 32'd1);
  endtask

  initial begin
    int s0;
    int r0;
    reset = 1'b1;
    start_req = 1'b0;
    tx_data = '0;
    data_len = '0;
    msb_first = 1'b0;
    spi_cs = 1'b1;
    tx_shift_en = 1'b0;
    rx_shift_en = 1'b0;
    miso = 1'b0;
`ifdef SPI_SHIFT_LOOPBACK_EN
    loopback = 1'b0;
`endif
    step(); step(); step();
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/start", 32'(start), 32'd0);
    check("rst/mosi", 32'(mosi), 32'd0);
    check("rst/rx_valid", 32'(rx_valid), 32'd0);
    check("rst/rx_data", 32'(rx_data), 32'd0);
    reset = 1'b0;
    step();

    // Directed cases
    xfer(16'h00A5, 8, 1'b1, 1, "a5_msb");
    xfer(16'h00A5, 8, 1'b0, 1, "a5_lsb");
    xfer(16'h1234, 0, 1'b1, 0, "len0");
    xfer(16'hBEEF, 20, 1'b1, 2, "len20_msb");
    xfer(16'h5A0F, 20, 1'b0, 2, "len20_lsb");
    xfer(16'h8001, 16, 1'b0, 0, "full_lsb");

    // A second request while busy, then a reset during SHIFT
    s0 = start_cnt;
    r0 = rxv_cnt;
    start_req = 1'b1; tx_data = 16'h1234; data_len = 8'd8; msb_first = 1'b1;
    step();
    start_req = 1'b0;
    step();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    spi_cs = 1'b0;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      tx_shift_en = 1'b1; step(); tx_shift_en = 1'b0;
      rx_shift_en = 1'b1; miso = 1'b1; step(); rx_shift_en = 1'b0;
    end
    check("busy_req/start_cnt", 32'(start_cnt - s0), 32'd1);
    check("busy_req/busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/mosi", 32'(mosi), 32'd0);
    spi_cs = 1'b1;
    step(); step(); step();
    check("abort/rxv_cnt", 32'(rxv_cnt - r0), 32'd0);
    check("abort/busy_later", 32'(busy), 32'd0);

    // A request made together with reset is dropped
    s0 = start_cnt;
    reset = 1'b1;
    start_req = 1'b1;
    step();
    reset = 1'b0;
    start_req = 1'b0;
    check("rst_req/busy", 32'(busy), 32'd0);
    step();
    check("rst_req/start_cnt", 32'(start_cnt - s0), 32'd0);
    check("rst_req/busy2", 32'(busy), 32'd0);

    // The held word is the last completed word
    xfer(16'h00C3, 8, 1'b1, 1, "after_rst");
    step(); step();
    check("hold/rx_data", 32'(rx_data), 32'h00C3);

`ifdef SPI_SHIFT_LOOPBACK_EN
    loopback = 1'b1;
    xfer(16'h003C, 8, 1'b1, 3, "loopback");
    check("loopback/rx_data", 32'(rx_data), 32'h003C);
    loopback = 1'b0;
`endif

    // Random transfers
    for (int t = 0; t < 20; t++) begin
      xfer(DW'($urandom), int'($urandom_range(0, 24)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 Parameter DATA_W, default 16, shall set the maximum word width in bits (range 8..32).
REQ-002 clk  in  1  system clock; the block shall be fully synchronous to its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 start_req  in  1  user request: start one transfer; accepted only when busy=0.
REQ-005 tx_data  in  DATA_W  word to transmit, right-justified; sampled on acceptance.
REQ-006 data_len  in  8  transfer length in bits; sampled on acceptance and also driven to the clk/cs generator.
REQ-007 msb_first  in  1  bit order: 1 = MSB first, 0 = LSB first; sampled on acceptance.
REQ-008 spi_cs  in  1  chip select from the clk/cs generator, active-low.
REQ-009 tx_shift_en  in  1  single-cycle strobe from the generator: present the next bit on mosi.
REQ-010 rx_shift_en  in  1  single-cycle strobe from the generator: sample miso.
REQ-011 miso  in  1  serial input, pre-synchronised.
REQ-012 start  out  1  single-cycle start pulse to the clk/cs generator.
REQ-013 mosi  out  1  registered serial output.
REQ-014 busy  out  1  high from acceptance through completion.
REQ-015 rx_data  out  DATA_W  received word, right-justified.
REQ-016 rx_valid  out  1  single-cycle pulse; rx_data is valid in the same cycle.

Function
REQ-017 FSM states IDLE, WAIT_CS, SHIFT, DONE shall be used; busy=0 only in IDLE.
REQ-018 IDLE & start_req shall latch the inputs, clamp len=min(data_len,DATA_W), load the tx shift register, pulse start for 1 cycle, clear the bit counter, and move to WAIT_CS on the next edge.
REQ-019 start_req while busy=1 shall be ignored, with no queueing.
REQ-020 WAIT_CS & spi_cs=0 shall move to SHIFT.
REQ-021 For msb_first=1 the tx register shall be loaded as tx_data<<(DATA_W-len) and shifted left, with the outgoing bit taken from bit DATA_W-1.
REQ-022 For msb_first=0 the tx register shall be loaded as tx_data, shifted right, with the outgoing bit taken from bit 0.
REQ-023 In SHIFT, each tx_shift_en shall register the outgoing bit onto mosi in the same edge as it shifts the register; bits beyond DATA_W shall drive 0.
REQ-024 In SHIFT, each rx_shift_en shall sample miso into the rx register and increment the bit counter, which saturates at 255.
REQ-025 For msb_first=1, rx shall shift left with miso entering bit 0.
REQ-026 For msb_first=0, rx shall shift right with miso entering bit DATA_W-1.
REQ-027 If tx_shift_en and rx_shift_en are asserted together, both actions shall execute.
REQ-028 SHIFT & spi_cs=1 shall move to DONE.
REQ-029 DONE shall update rx_data (msb_first=1: the rx register; msb_first=0: the rx register >>(DATA_W-len)), pulse rx_valid for 1 cycle, and return to IDLE on the next edge.
REQ-030 If data_len=0, no shift strobes occur; the transfer shall still complete with rx_valid=1 and rx_data=0.
REQ-031 If data_len>DATA_W, rx_data shall hold the last DATA_W received bits.
REQ-032 mosi shall be 0 in IDLE and WAIT_CS; rx_data shall hold its value until the next DONE.

Reset
REQ-033 Reset shall force state=IDLE, start=0, mosi=0, busy=0, rx_valid=0, rx_data=0, and clear the shift registers and bit counter.
REQ-034 Reset mid-transfer shall abort the transfer without issuing rx_valid; start_req asserted together with reset shall be ignored.

Configuration
REQ-035 With SPI_SHIFT_LOOPBACK_EN defined, an input loopback (1 bit) shall be added, and loopback=1 shall make the rx sampling use the registered mosi instead of miso.
REQ-036 Without SPI_SHIFT_LOOPBACK_EN, the loopback port and its mux shall be absent, and rx shall always sample miso.

Verification
REQ-037 DATA_W=16, data_len=8, msb_first=1, tx_data=0x00A5, miso echoing mosi -> mosi sequence 1,0,1,0,0,1,0,1; rx_valid once; rx_data=0x00A5.
REQ-038 Same stimulus with msb_first=0 -> mosi sequence 1,0,1,0,0,1,0,1 (LSB first); rx_data=0x00A5.
REQ-039 data_len=0 -> start pulse; no mosi activity; rx_valid once; rx_data=0x0000; busy returns to 0.
REQ-040 Second start_req while busy -> exactly one start pulse; reset asserted during SHIFT -> busy=0 next cycle, no rx_valid.
REQ-041 data_len=20 with DATA_W=16, miso constant 1 -> mosi=0 after bit 16; rx_data=0xFFFF.
REQ-042 SPI_SHIFT_LOOPBACK_EN defined, loopback=1, miso held 0, tx_data=0x3C, len=8 -> rx_data=0x003C.
